// File: rtl/aes_key_sched_ctrl_if.sv
// Bundle of key-load, key-generator and round-key read signals around the key schedule controller.
// The slave modport is the controller's view; master is the view of the surrounding logic.
interface aes_key_sched_ctrl_if #(
    parameter int KEY_W = 128
);
    logic             i_key_valid;
    logic             o_key_ready;
    logic [KEY_W-1:0] i_key;
    logic [KEY_W-1:0] o_pre_rnd_key;
    logic             o_en_key_gen;
    logic [3:0]       o_round_num;
    logic [KEY_W-1:0] i_next_rnd_key;
    logic             o_busy;
    logic             o_done;
    logic             o_keys_valid;
    logic             i_rd_en;
    logic [3:0]       i_rd_addr;
    logic [KEY_W-1:0] o_rd_key;
    logic             o_rd_valid;
    logic             o_rd_err;

    modport slave (
        input  i_key_valid, i_key, i_next_rnd_key, i_rd_en, i_rd_addr,
        output o_key_ready, o_pre_rnd_key, o_en_key_gen, o_round_num,
               o_busy, o_done, o_keys_valid, o_rd_key, o_rd_valid, o_rd_err
    );

    modport master (
        output i_key_valid, i_key, i_next_rnd_key, i_rd_en, i_rd_addr,
        input  o_key_ready, o_pre_rnd_key, o_en_key_gen, o_round_num,
               o_busy, o_done, o_keys_valid, o_rd_key, o_rd_valid, o_rd_err
    );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// AES round-key schedule sequencer: drives an external combinational key generator one round
// per cycle, buffers round keys 0..NUM_ROUNDS and serves them through a registered read port.
module aes_key_sched_ctrl #(
    parameter int KEY_W      = 128,
    parameter int NUM_ROUNDS = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    aes_key_sched_ctrl_if.slave  bus
);
    typedef enum logic {IDLE, EXPAND} state_t;

    state_t           state;
    logic [3:0]       rnd_cnt;
    logic [KEY_W-1:0] work_key;
    logic             key_ready;
    logic             busy;
    logic             en_key_gen;
    logic             done;
    logic             keys_valid;
    logic [KEY_W-1:0] rd_key;
    logic             rd_valid;
    logic             rd_err;
    logic [KEY_W-1:0] key_buf [NUM_ROUNDS+1];

    logic key_fire;
    logic last_rnd;
    logic rd_ok;

    assign key_fire = bus.i_key_valid && key_ready;
    assign last_rnd = (rnd_cnt == 4'(NUM_ROUNDS));
    assign rd_ok    = bus.i_rd_en && keys_valid && (bus.i_rd_addr <= 4'(NUM_ROUNDS));

    // Sequencer: every output is a register so the key generator sees clean, glitch-free controls
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            rnd_cnt    <= '0;
            work_key   <= '0;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
            en_key_gen <= 1'b0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_fire) begin
                        work_key   <= bus.i_key;
                        rnd_cnt    <= 4'd1;
                        keys_valid <= 1'b0;
                        key_ready  <= 1'b0;
                        busy       <= 1'b1;
                        en_key_gen <= 1'b1;
                        state      <= EXPAND;
                    end
                end
                EXPAND: begin
                    work_key <= bus.i_next_rnd_key;
                    if (last_rnd) begin
                        rnd_cnt    <= '0;
                        done       <= 1'b1;
                        keys_valid <= 1'b1;
                        key_ready  <= 1'b1;
                        busy       <= 1'b0;
                        en_key_gen <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        rnd_cnt <= rnd_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Key buffer: data only, contents are meaningless until keys_valid is set
    always_ff @(posedge i_clk) begin
        if (state == IDLE) begin
            if (key_fire) key_buf[0] <= bus.i_key;
        end else begin
            key_buf[rnd_cnt] <= bus.i_next_rnd_key;
        end
    end

    // Read port: one-cycle latency; uses pre-edge keys_valid so a re-key edge still returns the old schedule
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_key   <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            rd_err   <= bus.i_rd_en && !rd_ok;
            if (bus.i_rd_en) rd_key <= rd_ok ? key_buf[bus.i_rd_addr] : '0;
        end
    end

    assign bus.o_key_ready   = key_ready;
    assign bus.o_busy        = busy;
    assign bus.o_en_key_gen  = en_key_gen;
    assign bus.o_round_num   = rnd_cnt;
    assign bus.o_pre_rnd_key = work_key;
    assign bus.o_done        = done;
    assign bus.o_keys_valid  = keys_valid;
    assign bus.o_rd_key      = rd_key;
    assign bus.o_rd_valid    = rd_valid;
    assign bus.o_rd_err      = rd_err;
endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
- Sequences the combinational `aes_key_gen` round-key datapath.
- Accepts a 128-bit cipher key through a valid/ready handshake and drives `aes_key_gen` once per cycle for rounds 1..NUM_ROUNDS.
- Stores all round keys (0..NUM_ROUNDS) in an internal key buffer.
- Serves those keys to the AES round engine through a registered read port. Sits between key-load logic and the AES/GCM cipher core.

Parameters:
- KEY_W, 128, cipher/round key width in bits.
- NUM_ROUNDS, 10, number of expansion rounds (AES-128). Buffer depth = NUM_ROUNDS+1.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_key_valid  in  1  cipher key on i_key is valid.
- o_key_ready  out  1  controller can accept a key (state IDLE).
- i_key  in  KEY_W  cipher key (round 0 key).
- o_pre_rnd_key  out  KEY_W  to aes_key_gen.pre_rnd_key.
- o_en_key_gen  out  1  to aes_key_gen.i_en_key_gen.
- o_round_num  out  4  to aes_key_gen.round_num.
- i_next_rnd_key  in  KEY_W  from aes_key_gen.next_rnd_key (combinational, same-cycle).
- o_busy  out  1  expansion in progress.
- o_done  out  1  one-cycle pulse when expansion completes.
- o_keys_valid  out  1  key buffer holds a complete schedule.
- i_rd_en  in  1  round-key read request.
- i_rd_addr  in  4  round index 0..NUM_ROUNDS.
- o_rd_key  out  KEY_W  read data, one cycle after request.
- o_rd_valid  out  1  o_rd_key valid this cycle.
- o_rd_err  out  1  one-cycle pulse: out-of-range or not-ready read.

Behaviour:
- Reset (i_rst=1 at edge) values:
  - State IDLE; round counter 0.
  - o_key_ready=1 from the cycle after reset; all other outputs 0, including o_pre_rnd_key and o_rd_key.
  - Buffer contents are don't-care, but o_keys_valid=0.
  - Reset mid-expansion aborts immediately; no partial schedule is ever flagged valid.
- FSM states: IDLE, EXPAND.
- IDLE:
  - o_key_ready=1, o_en_key_gen=0, o_round_num=0.
  - On i_key_valid & o_key_ready at an edge:
    - buf[0] <= i_key; work_key <= i_key; rnd_cnt <= 1.
    - o_keys_valid <= 0; state <= EXPAND.
  - Re-keying while o_keys_valid=1 is legal and invalidates the old schedule at the handshake edge.
- EXPAND:
  - Combinational outputs: o_key_ready=0, o_busy=1, o_en_key_gen=1, o_round_num=rnd_cnt, o_pre_rnd_key=work_key.
  - At each edge:
    - buf[rnd_cnt] <= i_next_rnd_key; work_key <= i_next_rnd_key.
    - If rnd_cnt==NUM_ROUNDS: state <= IDLE, o_done <= 1 for one cycle, o_keys_valid <= 1. Otherwise rnd_cnt <= rnd_cnt+1.
  - i_key_valid is ignored while in EXPAND.
- Latency:
  - Handshake at edge E0; round writes at edges E1..E10.
  - o_done=1 and o_keys_valid=1 in the cycle following E10.
  - o_key_ready returns to 1 in that same cycle.
  - Total: NUM_ROUNDS+1 cycles from handshake to o_done.
- Read port, registered with 1-cycle latency:
  - Valid read: i_rd_en=1 at edge with o_keys_valid=1 and i_rd_addr<=NUM_ROUNDS. Next cycle o_rd_key=buf[i_rd_addr], o_rd_valid=1.
  - Invalid read: addr>NUM_ROUNDS or o_keys_valid=0. Next cycle o_rd_valid=0, o_rd_key=0, o_rd_err=1.
  - i_rd_en=0: o_rd_valid=0, o_rd_err=0, o_rd_key holds its last value.
  - Back-to-back reads are supported every cycle.
  - Read in the same cycle as a re-key handshake: the read is evaluated against the pre-edge o_keys_valid, so the old schedule is returned. buf[0] is overwritten at the same edge, but read data samples the old contents.
- o_busy and o_key_ready are mutually exclusive and never both 0 outside reset.

Test Plan:
- Reset then key 2b7e151628aed2a6abf7158809cf4f3c with i_key_valid=1 -> accepted next edge; o_round_num steps 1..10 on consecutive cycles; o_done pulses exactly 11 cycles after handshake; o_keys_valid=1.
- Read addr 0, 1, 10 after the previous test -> 2b7e1516…4f3c, a0fafe1788542cb123a339392a6c7605, d014f9a8c9ee2589e13f0cc8b6630ca6, each with o_rd_valid one cycle later.
- Read addr 11, and any read before first completion -> o_rd_err=1, o_rd_valid=0, o_rd_key=0.
- Assert i_rst at round 5 of expansion -> next cycle o_busy=0, o_keys_valid=0, o_key_ready=1; a following read of addr 3 returns o_rd_err=1.
- Hold i_key_valid=1 with a second key during EXPAND -> ignored; accepted only in the o_done cycle; o_keys_valid drops at that edge; new schedule valid 11 cycles later.
- Read addr 1 in the same cycle as the re-key handshake -> old round-1 key returned; immediately following reads return o_rd_err until the new o_done.
